// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: load-size encodings, hold-FSM states
// and the default datapath width.
package mem_wb_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// Little-endian byte/half/word extraction with sign or zero extension.
module load_extract
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [1:0]      size_i,
    input  logic            is_unsigned_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = word_i[8*gi +: 8];
    end

    assign byte_sel = lane[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

    always_comb begin
        result_o = word_i;
        case (size_i)
            LS_BYTE: result_o = {{(XLEN-8){byte_sel[7] & ~is_unsigned_i}}, byte_sel};
            LS_HALF: result_o = {{(XLEN-16){half_sel[15] & ~is_unsigned_i}}, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction; a hold register keeps the
// load word alive while the stage stalls, since mem_data is only valid one cycle.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_reg_write,
    input  logic            in_mem_to_reg,
    input  logic [1:0]      in_load_size,
    input  logic            in_load_unsigned,
    input  logic [1:0]      in_addr_lo,
    input  logic [RAW-1:0]  in_rd,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic            stall,
    input  logic            flush,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [RAW-1:0]  wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misaligned
);

    logic            valid_q, valid_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_to_reg_q, mem_to_reg_d;
    logic [1:0]      load_size_q, load_size_d;
    logic            load_unsigned_q, load_unsigned_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [RAW-1:0]  rd_q, rd_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] hold_q, hold_d;
    wb_state_e       state_q, state_d;

    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] load_value;

    always_comb begin
        valid_d         = valid_q;
        reg_write_d     = reg_write_q;
        mem_to_reg_d    = mem_to_reg_q;
        load_size_d     = load_size_q;
        load_unsigned_d = load_unsigned_q;
        addr_lo_d       = addr_lo_q;
        rd_d            = rd_q;
        alu_result_d    = alu_result_q;
        hold_d          = hold_q;
        state_d         = state_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d         = in_valid;
            reg_write_d     = in_reg_write;
            mem_to_reg_d    = in_mem_to_reg;
            load_size_d     = in_load_size;
            load_unsigned_d = in_load_unsigned;
            addr_lo_d       = in_addr_lo;
            rd_d            = in_rd;
            alu_result_d    = in_alu_result;
        end

        case (state_q)
            LIVE: begin
                // Capture the load word now; it disappears from mem_data next cycle.
                if (stall && !flush && valid_q && mem_to_reg_q) begin
                    state_d = HELD;
                    hold_d  = mem_data;
                end
            end
            HELD: begin
                if (!stall || flush) state_d = LIVE;
            end
            default: state_d = LIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            load_size_q     <= 2'b00;
            load_unsigned_q <= 1'b0;
            addr_lo_q       <= 2'b00;
            rd_q            <= '0;
            alu_result_q    <= '0;
            hold_q          <= '0;
            state_q         <= LIVE;
        end else begin
            valid_q         <= valid_d;
            reg_write_q     <= reg_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            load_size_q     <= load_size_d;
            load_unsigned_q <= load_unsigned_d;
            addr_lo_q       <= addr_lo_d;
            rd_q            <= rd_d;
            alu_result_q    <= alu_result_d;
            hold_q          <= hold_d;
            state_q         <= state_d;
        end
    end

    assign load_word = (state_q == HELD) ? hold_q : mem_data;

    load_extract #(
        .XLEN(XLEN)
    ) u_load_extract (
        .word_i        (load_word),
        .addr_lo_i     (addr_lo_q),
        .size_i        (load_size_q),
        .is_unsigned_i (load_unsigned_q),
        .result_o      (load_value)
    );

    // Size codes 10 and 11 are both word accesses, so size[1] alone means word.
    assign misaligned   = valid_q & mem_to_reg_q &
                          (((load_size_q == LS_HALF) & addr_lo_q[0]) |
                           (load_size_q[1] & (addr_lo_q != 2'b00)));
    assign wb_data      = mem_to_reg_q ? load_value : alu_result_q;
    assign wb_reg_write = valid_q & reg_write_q & (rd_q != '0) & ~misaligned;
    assign wb_valid     = valid_q;
    assign wb_rd        = rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_reg_write, in_mem_to_reg, in_load_unsigned;
    logic [1:0]  in_load_size, in_addr_lo;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result, mem_data;
    logic        stall, flush;
    logic        wb_valid, wb_reg_write, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .RAW(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_reg_write     (in_reg_write),
        .in_mem_to_reg    (in_mem_to_reg),
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_addr_lo       (in_addr_lo),
        .in_rd            (in_rd),
        .in_alu_result    (in_alu_result),
        .mem_data         (mem_data),
        .stall            (stall),
        .flush            (flush),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .misaligned       (misaligned)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic m2r, input logic [1:0] sz, input logic uns,
                           input logic [1:0] a, input logic [4:0] rd, input logic [31:0] alu);
        in_valid         = 1'b1;
        in_reg_write     = 1'b1;
        in_mem_to_reg    = m2r;
        in_load_size     = sz;
        in_load_unsigned = uns;
        in_addr_lo       = a;
        in_rd            = rd;
        in_alu_result    = alu;
    endtask

    // One instruction through the stage; mem_data arrives in its WB cycle.
    task automatic run_vec(input string tag, input logic m2r, input logic [1:0] sz,
                           input logic uns, input logic [1:0] a, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] mem,
                           input logic [31:0] exp_data, input logic exp_rw, input logic exp_mis);
        present(m2r, sz, uns, a, rd, alu);
        tick();
        in_valid = 1'b0;
        mem_data = mem;
        #1;
        check_vec({tag, ".valid"}, {31'b0, wb_valid}, 32'h1);
        check_vec({tag, ".data"}, wb_data, exp_data);
        check_vec({tag, ".rw"}, {31'b0, wb_reg_write}, {31'b0, exp_rw});
        check_vec({tag, ".rd"}, {27'b0, wb_rd}, {27'b0, rd});
        check_vec({tag, ".mis"}, {31'b0, misaligned}, {31'b0, exp_mis});
    endtask

    task automatic check_idle(input string tag);
        check_vec({tag, ".valid"}, {31'b0, wb_valid}, 32'h0);
        check_vec({tag, ".rw"}, {31'b0, wb_reg_write}, 32'h0);
        check_vec({tag, ".rd"}, {27'b0, wb_rd}, 32'h0);
        check_vec({tag, ".data"}, wb_data, 32'h0);
        check_vec({tag, ".mis"}, {31'b0, misaligned}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
        in_load_size = 2'b00; in_load_unsigned = 1'b0; in_addr_lo = 2'b00;
        in_rd = 5'd0; in_alu_result = 32'h0; mem_data = 32'hDEADBEEF;
        tick(); tick();
        check_idle("reset");
        reset = 1'b1;

        // Extraction patterns on word 0x80FF7F01
        run_vec("lb_s_a3",  1'b1, LS_BYTE, 1'b0, 2'd3, 5'd5, 32'h0, 32'h80FF7F01, 32'hFFFFFF80, 1'b1, 1'b0);
        run_vec("lhu_a2",   1'b1, LS_HALF, 1'b1, 2'd2, 5'd6, 32'h0, 32'h80FF7F01, 32'h000080FF, 1'b1, 1'b0);
        run_vec("lh_s_a2",  1'b1, LS_HALF, 1'b0, 2'd2, 5'd6, 32'h0, 32'h80FF7F01, 32'hFFFF80FF, 1'b1, 1'b0);
        run_vec("lh_s_a0",  1'b1, LS_HALF, 1'b0, 2'd0, 5'd7, 32'h0, 32'h80FF7F01, 32'h00007F01, 1'b1, 1'b0);
        run_vec("lb_s_a2",  1'b1, LS_BYTE, 1'b0, 2'd2, 5'd8, 32'h0, 32'h80FF7F01, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_vec("lbu_a1",   1'b1, LS_BYTE, 1'b1, 2'd1, 5'd9, 32'h0, 32'h80FF7F01, 32'h0000007F, 1'b1, 1'b0);
        run_vec("lbu_a3",   1'b1, LS_BYTE, 1'b1, 2'd3, 5'd9, 32'h0, 32'h80FF7F01, 32'h00000080, 1'b1, 1'b0);
        run_vec("lw_sz11",  1'b1, 2'b11,   1'b0, 2'd0, 5'd10, 32'h0, 32'h80FF7F01, 32'h80FF7F01, 1'b1, 1'b0);
        run_vec("alu",      1'b0, LS_WORD, 1'b0, 2'd1, 5'd11, 32'h1234, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0);
        run_vec("rd0",      1'b0, LS_WORD, 1'b0, 2'd0, 5'd0, 32'h55, 32'h0, 32'h00000055, 1'b0, 1'b0);
        run_vec("lw_mis_a1",1'b1, LS_WORD, 1'b0, 2'd1, 5'd12, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b1);
        run_vec("lh_mis_a1",1'b1, LS_HALF, 1'b0, 2'd1, 5'd13, 32'h0, 32'h80FF7F01, 32'h00007F01, 1'b0, 1'b1);

        // Stall hold: the load word must survive mem_data going to zero
        run_vec("st_lw", 1'b1, LS_WORD, 1'b0, 2'd0, 5'd3, 32'h0, 32'h12345678, 32'h12345678, 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_data = 32'h0;
            #1;
            check_vec($sformatf("stall%0d.data", i), wb_data, 32'h12345678);
            check_vec($sformatf("stall%0d.rd", i), {27'b0, wb_rd}, 32'd3);
        end
        stall = 1'b0;
        run_vec("post_stall", 1'b1, LS_WORD, 1'b0, 2'd0, 5'd4, 32'h0, 32'hCAFEBABE, 32'hCAFEBABE, 1'b1, 1'b0);
        check_vec("post_stall.state", {31'b0, dut.state_q}, {31'b0, LIVE});

        // Flush beats stall
        run_vec("fl_pre", 1'b0, LS_WORD, 1'b0, 2'd0, 5'd14, 32'h77, 32'h0, 32'h00000077, 1'b1, 1'b0);
        stall = 1'b1; flush = 1'b1;
        tick();
        check_vec("flush.valid", {31'b0, wb_valid}, 32'h0);
        check_vec("flush.rw", {31'b0, wb_reg_write}, 32'h0);
        stall = 1'b0; flush = 1'b0;

        // Reset while HELD discards the held word
        run_vec("rh_lw", 1'b1, LS_WORD, 1'b0, 2'd0, 5'd7, 32'h0, 32'hAAAA5555, 32'hAAAA5555, 1'b1, 1'b0);
        stall = 1'b1;
        tick();
        mem_data = 32'h0;
        #1;
        check_vec("held.data", wb_data, 32'hAAAA5555);
        check_vec("held.state", {31'b0, dut.state_q}, {31'b0, HELD});
        reset = 1'b0;
        tick();
        check_idle("rst_held");
        check_vec("rst_held.state", {31'b0, dut.state_q}, {31'b0, LIVE});
        reset = 1'b1; stall = 1'b0;
        run_vec("after_rst", 1'b1, LS_WORD, 1'b0, 2'd0, 5'd8, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
